// File: rtl/vga_lcd_pkg.sv
// Shared definitions for the LCD video-memory prefetch engine.
// FSM encoding and Wishbone constants.
package vga_lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [1:0] WB_SEL_WORD = 2'b11;

endpackage

// File: rtl/vga_fifo.sv
// Synchronous FIFO with synchronous clear and word count.
// Read data is the head entry, valid whenever the FIFO is not empty.
module vga_fifo
    import vga_lcd_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          sclr,
    input  logic          wreq,
    input  logic [DW-1:0] d,
    input  logic          rreq,
    output logic [DW-1:0] q,
    output logic [AW:0]   nword,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        wr_en = wreq && !full;
        rd_en = rreq && !empty;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (sclr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en) wp_d = wp_q + AW'(1);
            if (rd_en) rp_d = rp_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !sclr) mem_q[wp_q] <= d;
    end

    assign q     = mem_q[rp_q];
    assign nword = cnt_q;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_W);

endmodule

// File: rtl/vga_lcd_fetch.sv
// Wishbone master that prefetches one scan line of 16-bit video
// words into a local FIFO, refilling at a low-water mark.
module vga_lcd_fetch
    import vga_lcd_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int LOW_WATER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] start_addr,
    input  logic [9:0]  line_words,
    input  logic [9:0]  stride,
    input  logic        frame_start,
    input  logic        line_start,
    output logic [16:0] lcd_adr_o,
    input  logic [15:0] lcd_dat_i,
    output logic [1:0]  lcd_sel_o,
    output logic        lcd_cyc_o,
    output logic        lcd_stb_o,
    input  logic        lcd_ack_i,
    input  logic        rd_req,
    output logic [15:0] rd_dat,
    output logic        rd_valid,
    output logic        fifo_empty,
    output logic        underrun
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LOW_W  = (FIFO_AW+1)'(LOW_WATER);
    localparam logic [FIFO_AW:0] LAST_W = (FIFO_AW+1)'(DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic [16:0]  line_base_q, line_base_d;
    logic [9:0]   word_cnt_q, word_cnt_d;
    logic [16:0]  adr_q, adr_d;
    logic         first_q, first_d;
    logic         ls_pend_q, ls_pend_d;
    logic         underrun_q, underrun_d;
    logic         rd_valid_q, rd_valid_d;
    logic [15:0]  rd_dat_q, rd_dat_d;

    logic [FIFO_AW:0] nword;
    logic [15:0]      fifo_q;
    logic             fifo_full;
    logic             fifo_clr;
    logic             push;
    logic             pop;
    logic             ls_now;
    logic [9:0]       cnt_inc;

    assign pop      = rd_req && !fifo_empty;
    assign fifo_clr = !rst || frame_start;

    vga_fifo #(
        .AW (FIFO_AW),
        .DW (16)
    ) u_fifo (
        .clk   (clk),
        .sclr  (fifo_clr),
        .wreq  (push),
        .d     (lcd_dat_i),
        .rreq  (pop),
        .q     (fifo_q),
        .nword (nword),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        word_cnt_d  = word_cnt_q;
        first_d     = first_q;
        ls_pend_d   = ls_pend_q;
        adr_d       = adr_q;
        push        = 1'b0;
        cnt_inc     = word_cnt_q + 10'd1;
        // The first line_start of a frame marks line 0, already loaded.
        ls_now      = line_start && !first_q;
        if (frame_start) begin
            line_base_d = start_addr;
            word_cnt_d  = '0;
            first_d     = 1'b1;
            ls_pend_d   = 1'b0;
            if ((state_q == ST_FETCH || state_q == ST_DRAIN)
                && !lcd_ack_i)
                state_d = ST_DRAIN;
            else
                state_d = ST_IDLE;
        end else begin
            if (line_start) first_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (ls_now) begin
                        line_base_d = line_base_q + 17'(stride);
                        word_cnt_d  = '0;
                    end else if (word_cnt_q < line_words
                                 && nword <= LOW_W
                                 && !fifo_full) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (ls_now) begin
                        line_base_d = line_base_q + 17'(stride);
                        word_cnt_d  = '0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (lcd_ack_i) begin
                        push       = 1'b1;
                        word_cnt_d = cnt_inc;
                        if (ls_now || ls_pend_q) begin
                            line_base_d = line_base_q + 17'(stride);
                            word_cnt_d  = '0;
                            ls_pend_d   = 1'b0;
                            state_d     = ST_IDLE;
                        end else if (cnt_inc >= line_words) begin
                            state_d = ST_HOLD;
                        end else if (nword == LAST_W && !pop) begin
                            state_d = ST_IDLE;
                        end
                    end else if (ls_now) begin
                        ls_pend_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (lcd_ack_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_FETCH)
            adr_d = line_base_d + 17'(word_cnt_d);
    end

    always_comb begin
        rd_valid_d = pop;
        rd_dat_d   = pop ? fifo_q : rd_dat_q;
        if (frame_start)
            underrun_d = 1'b0;
        else
            underrun_d = underrun_q || (rd_req && fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            line_base_q <= '0;
            word_cnt_q  <= '0;
            adr_q       <= '0;
            first_q     <= 1'b1;
            ls_pend_q   <= 1'b0;
            underrun_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_dat_q    <= '0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            word_cnt_q  <= word_cnt_d;
            adr_q       <= adr_d;
            first_q     <= first_d;
            ls_pend_q   <= ls_pend_d;
            underrun_q  <= underrun_d;
            rd_valid_q  <= rd_valid_d;
            rd_dat_q    <= rd_dat_d;
        end
    end

    assign lcd_cyc_o = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign lcd_stb_o = lcd_cyc_o;
    assign lcd_sel_o = lcd_stb_o ? WB_SEL_WORD : 2'b00;
    assign lcd_adr_o = adr_q;
    assign rd_dat    = rd_dat_q;
    assign rd_valid  = rd_valid_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_vga_lcd_fetch.sv
// Directed bench for vga_lcd_fetch with a latency-programmable
// Wishbone slave whose data is a fixed function of the address.
module tb_vga_lcd_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] start_addr;
    logic [9:0]  line_words;
    logic [9:0]  stride;
    logic        frame_start;
    logic        line_start;
    logic [16:0] lcd_adr_o;
    logic [15:0] lcd_dat_i;
    logic [1:0]  lcd_sel_o;
    logic        lcd_cyc_o;
    logic        lcd_stb_o;
    logic        lcd_ack_i;
    logic        rd_req;
    logic [15:0] rd_dat;
    logic        rd_valid;
    logic        fifo_empty;
    logic        underrun;

    int n_vec = 0;
    int n_err = 0;
    int lat = 0;
    int wcnt = 0;
    logic slave_en = 1'b0;
    logic ack_force = 1'b0;
    logic [16:0] acks[$];

    vga_lcd_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start_addr  (start_addr),
        .line_words  (line_words),
        .stride      (stride),
        .frame_start (frame_start),
        .line_start  (line_start),
        .lcd_adr_o   (lcd_adr_o),
        .lcd_dat_i   (lcd_dat_i),
        .lcd_sel_o   (lcd_sel_o),
        .lcd_cyc_o   (lcd_cyc_o),
        .lcd_stb_o   (lcd_stb_o),
        .lcd_ack_i   (lcd_ack_i),
        .rd_req      (rd_req),
        .rd_dat      (rd_dat),
        .rd_valid    (rd_valid),
        .fifo_empty  (fifo_empty),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] md(input logic [16:0] a);
        return a[15:0] ^ 16'h3c00;
    endfunction

    assign lcd_dat_i = md(lcd_adr_o);
    assign lcd_ack_i = ack_force
                     | (slave_en && lcd_stb_o && wcnt == lat);

    always @(posedge clk) begin
        if (lcd_stb_o && lcd_ack_i) acks.push_back(lcd_adr_o);
        if (!lcd_stb_o || lcd_ack_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ack_at(input int i);
        if (i < acks.size()) return 32'(acks[i]);
        return 32'hdead_beef;
    endfunction

    task automatic frame(input logic [16:0] sa, input logic [9:0] lw,
                         input logic [9:0] st);
        @(negedge clk);
        start_addr  = sa;
        line_words  = lw;
        stride      = st;
        frame_start = 1'b1;
        acks.delete();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic line_pulse();
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic pop_one(input logic [15:0] exp);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        chk("rd_valid", 32'(rd_valid), 32'd1);
        chk("rd_dat", 32'(rd_dat), 32'(exp));
    endtask

    task automatic wait_cyc(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_cyc_o) break;
        end
        chk(tag, 32'(lcd_cyc_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        start_addr = '0;
        line_words = '0;
        stride = '0;
        frame_start = 1'b0;
        line_start = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(lcd_cyc_o), 32'd0);
        chk("rst_stb", 32'(lcd_stb_o), 32'd0);
        chk("rst_sel", 32'(lcd_sel_o), 32'd0);
        chk("rst_adr", 32'(lcd_adr_o), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_rdd", 32'(rd_dat), 32'd0);
        chk("rst_und", 32'(underrun), 32'd0);
        chk("rst_emp", 32'(fifo_empty), 32'd1);
        rst = 1'b1;
        slave_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("lw0_idle", 32'(lcd_cyc_o), 32'd0);

        // zero-latency line of 8 words
        lat = 0;
        frame(17'h100, 10'd8, 10'd8);
        repeat (30) @(negedge clk);
        chk("t1_nack", 32'(acks.size()), 32'd8);
        chk("t1_a0", ack_at(0), 32'h100);
        chk("t1_a7", ack_at(7), 32'h107);
        chk("t1_hold", 32'(lcd_cyc_o), 32'd0);
        chk("t1_nemp", 32'(fifo_empty), 32'd0);
        for (int i = 0; i < 8; i++) pop_one(md(17'(32'h100 + i)));
        chk("t1_emp", 32'(fifo_empty), 32'd1);

        // fill to full, then low-water refill
        lat = 3;
        frame(17'h0, 10'd40, 10'd40);
        repeat (100) @(negedge clk);
        chk("t2_nack", 32'(acks.size()), 32'd16);
        chk("t2_a0", ack_at(0), 32'h0);
        chk("t2_a15", ack_at(15), 32'hf);
        chk("t2_full", 32'(lcd_cyc_o), 32'd0);
        for (int i = 0; i < 7; i++) pop_one(md(17'(i)));
        repeat (4) @(negedge clk);
        chk("t2_above_lw", 32'(acks.size()), 32'd16);
        pop_one(md(17'd7));
        repeat (60) @(negedge clk);
        chk("t2_refill_n", 32'(acks.size()), 32'd24);
        chk("t2_a16", ack_at(16), 32'h10);
        chk("t2_a23", ack_at(23), 32'h17);

        // three lines with steady consumption
        lat = 1;
        frame(17'h0, 10'd40, 10'd40);
        line_pulse();
        repeat (10) @(negedge clk);
        for (int l = 0; l < 3; l++) begin
            if (l > 0) begin
                line_pulse();
                repeat (10) @(negedge clk);
            end
            for (int k = 0; k < 40; k++) begin
                pop_one(md(17'(l * 40 + k)));
                repeat (2) @(negedge clk);
            end
        end
        chk("t3_und", 32'(underrun), 32'd0);
        chk("t3_nack", 32'(acks.size()), 32'd120);
        chk("t3_l1", ack_at(40), 32'd40);
        chk("t3_l2", ack_at(80), 32'd80);
        chk("t3_last", ack_at(119), 32'd119);

        // read while empty
        chk("t5_emp", 32'(fifo_empty), 32'd1);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        chk("t5_rdv", 32'(rd_valid), 32'd0);
        chk("t5_und", 32'(underrun), 32'd1);
        repeat (5) @(negedge clk);
        chk("t5_sticky", 32'(underrun), 32'd1);

        // frame_start one cycle into a pending access
        lat = 3;
        frame(17'h200, 10'd40, 10'd40);
        chk("t4_und_clr", 32'(underrun), 32'd0);
        wait_cyc("t4_cyc");
        chk("t4_adr0", 32'(lcd_adr_o), 32'h200);
        frame(17'h300, 10'd40, 10'd40);
        chk("t4_drain_cyc", 32'(lcd_cyc_o), 32'd1);
        chk("t4_drain_adr", 32'(lcd_adr_o), 32'h200);
        chk("t4_drain_sel", 32'(lcd_sel_o), 32'd3);
        repeat (30) @(negedge clk);
        chk("t4_drained", ack_at(0), 32'h200);
        chk("t4_next", ack_at(1), 32'h300);
        pop_one(md(17'h300));
        chk("t4_und", 32'(underrun), 32'd0);

        // reset during an access, then a stray ack
        wait_cyc("t6_cyc");
        rst = 1'b0;
        line_words = '0;
        slave_en = 1'b0;
        @(negedge clk);
        chk("t6_cyc0", 32'(lcd_cyc_o), 32'd0);
        chk("t6_stb0", 32'(lcd_stb_o), 32'd0);
        chk("t6_sel0", 32'(lcd_sel_o), 32'd0);
        chk("t6_adr0", 32'(lcd_adr_o), 32'd0);
        chk("t6_emp", 32'(fifo_empty), 32'd1);
        chk("t6_rdd", 32'(rd_dat), 32'd0);
        rst = 1'b1;
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        chk("t6_late_ack", 32'(fifo_empty), 32'd1);
        repeat (5) @(negedge clk);
        chk("t6_emp2", 32'(fifo_empty), 32'd1);
        chk("t6_idle", 32'(lcd_cyc_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
